chan_pulse_buf_writer: RTL and testbench

- User-clock stage that packs detected pulse events into 64-bit words and writes them into the pulse buffer BRAM, one word per cycle.
- Sequential addressing with wrap-around.
- Publishes a registered 32-bit write pointer, pulses_addr. This output drives user_data_in of the downstream software register that the PPC polls over OPB to locate new pulses.

---
 rtl/chan_pulse_pkg.sv | 24 ++
 rtl/pulse_skid_fifo.sv | 55 +++++
 rtl/chan_pulse_buf_writer.sv | 119 +++++++++++
 tb/tb_chan_pulse_buf_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pulse_pkg.sv
// Shared types for the pulse buffer writer: event field widths, the packed
// 64-bit BRAM word layout and the writer FSM states.
package chan_pulse_pkg;

  localparam int CHAN_W = 8;
  localparam int TS_W   = 20;
  localparam int PH_W   = 16;
  localparam int BASE_W = 20;

  // Field order gives [63:56] chan, [55:36] ts, [35:20] phase, [19:0] base.
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [TS_W-1:0]   ts;
    logic [PH_W-1:0]   phase;
    logic [BASE_W-1:0] base;
  } pulse_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_skid_fifo.sv
// Small synchronous FIFO of packed pulse words with occupancy count.
// Push when full and pop when empty are ignored.
module pulse_skid_fifo
  import chan_pulse_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  pulse_word_t              din,
  output pulse_word_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  pulse_word_t   mem [DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + 1'b1;
      if (do_pop)  rd_idx <= rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chan_pulse_buf_writer.sv
// Packs pulse events into 64-bit words and writes them sequentially into the
// pulse BRAM with wrap-around. Optional drop counter: CHAN_PULSE_DROP_CNT_EN.
module chan_pulse_buf_writer
  import chan_pulse_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic              enable,
  input  logic              pulse_valid,
  output logic              pulse_ready,
  input  logic [7:0]        pulse_chan,
  input  logic [19:0]       pulse_ts,
  input  logic [15:0]       pulse_phase,
  input  logic [19:0]       pulse_base,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [63:0]       bram_din,
  output logic [31:0]       pulses_addr
`ifdef CHAN_PULSE_DROP_CNT_EN
  ,
  output logic [31:0]       drop_cnt
`endif
);

  state_t                      state;
  state_t                      state_nxt;
  pulse_word_t                 in_word;
  pulse_word_t                 out_word;
  logic                        push;
  logic                        pop;
  logic                        clear_ptr;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [ADDR_W-1:0]           wr_ptr;
  logic                        wrap;

  assign in_word     = {pulse_chan, pulse_ts, pulse_phase, pulse_base};
  // Handshake: an event transfers on a cycle with pulse_valid && pulse_ready;
  // ready never waits on valid, and an offered event that is not taken is lost.
  assign pulse_ready = (state == RUN) && !fifo_full;
  assign push        = pulse_valid && pulse_ready;

  pulse_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (user_clk),
    .rst   (user_rst),
    .push  (push),
    .pop   (pop),
    .din   (in_word),
    .dout  (out_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clear_ptr = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          clear_ptr = 1'b1;
        end
      end
      RUN: begin
        pop = !fifo_empty;
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        pop = !fifo_empty;
        if (fifo_count == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pulses_addr trails wr_ptr by one edge so it never leads the written data.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state       <= IDLE;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      wr_ptr      <= '0;
      wrap        <= 1'b0;
      pulses_addr <= '0;
    end else begin
      state       <= state_nxt;
      bram_we     <= pop;
      pulses_addr <= {wrap, {(31-ADDR_W){1'b0}}, wr_ptr};
      if (pop) begin
        bram_addr <= wr_ptr;
        bram_din  <= out_word;
        wr_ptr    <= wr_ptr + 1'b1;
        if (&wr_ptr) wrap <= ~wrap;
      end
      if (clear_ptr) begin
        wr_ptr <= '0;
        wrap   <= 1'b0;
      end
    end
  end

`ifdef CHAN_PULSE_DROP_CNT_EN
  always_ff @(posedge user_clk) begin
    if (user_rst || clear_ptr) begin
      drop_cnt <= '0;
    end else if (pulse_valid && !pulse_ready && (state != IDLE) && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_pulse_buf_writer.sv
// Directed bench for chan_pulse_buf_writer: single-event latency, full buffer
// lap, drain, re-enable after wrap and mid-run reset.
module tb_chan_pulse_buf_writer;

  localparam int ADDR_W     = 14;
  localparam int FIFO_DEPTH = 2;
  localparam int N_LAP      = (1 << ADDR_W) + 3;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic              enable;
  logic              pulse_valid;
  logic              pulse_ready;
  logic [7:0]        pulse_chan;
  logic [19:0]       pulse_ts;
  logic [15:0]       pulse_phase;
  logic [19:0]       pulse_base;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [63:0]       bram_din;
  logic [31:0]       pulses_addr;
`ifdef CHAN_PULSE_DROP_CNT_EN
  logic [31:0]       drop_cnt;
`endif

  int                total = 0;
  int                bad   = 0;
  int                wr_cnt = 0;
  int                wr_base;
  logic [63:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;

  chan_pulse_buf_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .enable      (enable),
    .pulse_valid (pulse_valid),
    .pulse_ready (pulse_ready),
    .pulse_chan  (pulse_chan),
    .pulse_ts    (pulse_ts),
    .pulse_phase (pulse_phase),
    .pulse_base  (pulse_base),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .pulses_addr (pulses_addr)
`ifdef CHAN_PULSE_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] w);
    pulse_valid = v;
    {pulse_chan, pulse_ts, pulse_phase, pulse_base} = w;
  endtask

  function automatic logic [63:0] mk(input int i);
    logic [7:0]  c;
    logic [19:0] t;
    logic [15:0] p;
    logic [19:0] b;
    c = i[7:0];
    t = 20'(i * 7);
    p = 16'(i * 13 + 5);
    b = 20'(i ^ 32'h000A_5A5A);
    return {c, t, p, b};
  endfunction

  // scoreboard: every BRAM write must match the next expected word and address
  always @(negedge user_clk) begin
    if (bram_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        check("we_din", bram_din, exp_q.pop_front());
        check("we_addr", 64'(bram_addr), 64'(exp_addr));
        exp_addr = exp_addr + 1'b1;
      end
    end
  end

  initial begin
    user_rst = 1'b1;
    enable   = 1'b0;
    drive(1'b0, 64'd0);
    tick();
    tick();
    check("rst_we", 64'(bram_we), 64'd0);
    check("rst_addr", 64'(bram_addr), 64'd0);
    check("rst_din", bram_din, 64'd0);
    check("rst_paddr", 64'(pulses_addr), 64'd0);
    check("rst_ready", 64'(pulse_ready), 64'd0);
`ifdef CHAN_PULSE_DROP_CNT_EN
    check("rst_drop", 64'(drop_cnt), 64'd0);
`endif

    // single event latency
    user_rst = 1'b0;
    enable   = 1'b1;
    tick();
    check("run_ready", 64'(pulse_ready), 64'd1);
    drive(1'b1, 64'h1200_ABC7_FFFF_FFFF);
    exp_q.push_back(64'h1200_ABC7_FFFF_FFFF);
    tick();
    check("t0_we", 64'(bram_we), 64'd0);
    drive(1'b0, 64'd0);
    tick();
    check("t1_we", 64'(bram_we), 64'd1);
    check("t1_addr", 64'(bram_addr), 64'd0);
    check("t1_din", bram_din, 64'h1200_ABC7_FFFF_FFFF);
    check("t1_paddr", 64'(pulses_addr), 64'd0);
    tick();
    check("t2_paddr", 64'(pulses_addr), 64'h0000_0001);
    check("t2_we", 64'(bram_we), 64'd0);

    // restart a run so the lap starts at address 0
    enable = 1'b0;
    tick();
    tick();
    check("idle_ready", 64'(pulse_ready), 64'd0);
    enable = 1'b1;
    tick();
    tick();
    check("restart_paddr", 64'(pulses_addr), 64'd0);
    exp_addr = '0;

    // continuous valid across one full lap plus three words
    wr_base = wr_cnt;
    for (int i = 0; i < N_LAP; i++) begin
      drive(1'b1, mk(i));
      exp_q.push_back(mk(i));
      tick();
    end
    drive(1'b0, 64'd0);
    tick();
    tick();
    check("lap_paddr", 64'(pulses_addr), 64'h8000_0003);
    check("lap_writes", 64'(wr_cnt - wr_base), 64'(N_LAP));
    check("lap_q_empty", 64'(exp_q.size()), 64'd0);

    // drop enable while events are still in flight
    wr_base = wr_cnt;
    drive(1'b1, mk(100));
    exp_q.push_back(mk(100));
    tick();
    drive(1'b1, mk(101));
    exp_q.push_back(mk(101));
    tick();
    drive(1'b1, mk(102));
    exp_q.push_back(mk(102));
    enable = 1'b0;
    tick();
    check("drain0_ready", 64'(pulse_ready), 64'd0);
    drive(1'b1, mk(103));
    tick();
    check("drain1_ready", 64'(pulse_ready), 64'd0);
    check("drain1_we", 64'(bram_we), 64'd1);
    tick();
    check("drain2_ready", 64'(pulse_ready), 64'd0);
    check("drain2_we", 64'(bram_we), 64'd0);
    tick();
    check("idle_ready2", 64'(pulse_ready), 64'd0);
    check("idle_we", 64'(bram_we), 64'd0);
    check("drain_writes", 64'(wr_cnt - wr_base), 64'd3);
    check("drain_paddr", 64'(pulses_addr), 64'h8000_0006);
`ifdef CHAN_PULSE_DROP_CNT_EN
    check("drain_drop", 64'(drop_cnt), 64'd2);
`endif
    drive(1'b0, 64'd0);

    // re-enable after the wrap
    enable = 1'b1;
    tick();
`ifdef CHAN_PULSE_DROP_CNT_EN
    check("reen_drop", 64'(drop_cnt), 64'd0);
`endif
    tick();
    check("reen_paddr", 64'(pulses_addr), 64'd0);
    exp_addr = '0;
    drive(1'b1, mk(200));
    exp_q.push_back(mk(200));
    tick();
    drive(1'b0, 64'd0);
    tick();
    check("reen_we", 64'(bram_we), 64'd1);
    check("reen_addr", 64'(bram_addr), 64'd0);
    tick();
    check("reen_paddr1", 64'(pulses_addr), 64'h0000_0001);

    // reset in the middle of a stream with an entry still queued
    drive(1'b1, mk(300));
    exp_q.push_back(mk(300));
    tick();
    drive(1'b1, mk(301));
    exp_q.push_back(mk(301));
    tick();
    user_rst = 1'b1;
    drive(1'b1, mk(302));
    tick();
    check("mrst_we", 64'(bram_we), 64'd0);
    check("mrst_addr", 64'(bram_addr), 64'd0);
    check("mrst_din", bram_din, 64'd0);
    check("mrst_paddr", 64'(pulses_addr), 64'd0);
    check("mrst_ready", 64'(pulse_ready), 64'd0);
    exp_q.delete();
    user_rst = 1'b0;
    drive(1'b0, 64'd0);
    wr_base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we", 64'(bram_we), 64'd0);
    end
    check("post_rst_writes", 64'(wr_cnt - wr_base), 64'd0);
    check("post_rst_paddr", 64'(pulses_addr), 64'd0);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
